// File: rtl/button_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : button_scan_controller_if
// Description : Event-queue handshake between the button scan controller and
//               the game logic that drains it.
//                 read_en     - consumer pops the head event
//                 event_valid - queue non-empty, head is presented
//                 event_id    - button index of the head event
//                 event_press - 1 = press, 0 = release
//                 fifo_full   - queue holds FIFO_DEPTH entries
//                 overflow    - sticky, an undelivered event was overwritten
//               master = controller side, slave = game-logic side.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_scan_controller_if #(
    parameter int N_BUTTONS = 4
);
    localparam int c_id_w = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;

    logic              read_en;
    logic              event_valid;
    logic [c_id_w-1:0] event_id;
    logic              event_press;
    logic              fifo_full;
    logic              overflow;

    modport master (
        input  read_en,
        output event_valid,
        output event_id,
        output event_press,
        output fifo_full,
        output overflow
    );

    modport slave (
        output read_en,
        input  event_valid,
        input  event_id,
        input  event_press,
        input  fifo_full,
        input  overflow
    );
endinterface
`default_nettype wire

// File: rtl/button_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : button_scan_controller
// Description : Controller-pad front end. Synchronizes N raw buttons, samples
//               them on a shared prescaled tick, debounces each one with its
//               own stability counter and turns every accepted level change
//               into a press/release event. A round-robin arbiter pushes the
//               pending events into a first-word-fall-through queue.
// Ports       : clk     - system clock
//               reset_n - asynchronous reset, active-low
//               buttons - raw asynchronous button levels, 1 = pressed
//               state   - debounced level per button
//               evt     - event queue handshake (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module button_scan_controller #(
    parameter int N_BUTTONS    = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic [N_BUTTONS-1:0]  buttons,
    output      logic [N_BUTTONS-1:0]  state,
    button_scan_controller_if.master   evt
);

    localparam int c_id_w  = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
    localparam int c_pre_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_cnt_w = $clog2(STABLE_TICKS + 1);
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_occ_w = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_pre_w-1:0] c_tick_last = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(STABLE_TICKS - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(FIFO_DEPTH - 1);
    localparam logic [c_occ_w-1:0] c_occ_full  = c_occ_w'(FIFO_DEPTH);
    localparam logic [c_id_w-1:0]  c_last_rst  = c_id_w'(N_BUTTONS - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [N_BUTTONS-1:0] r_sync1;
    logic [N_BUTTONS-1:0] r_sync2;
    logic [c_pre_w-1:0]   r_pre;
    logic [c_cnt_w-1:0]   r_cnt [N_BUTTONS];
    logic [N_BUTTONS-1:0] r_state;
    logic [N_BUTTONS-1:0] r_pend;
    logic [N_BUTTONS-1:0] r_kind;
    logic                 r_overflow;
    logic [c_id_w-1:0]    r_last;

    // Queue entry layout: {button index, press flag}
    logic [c_id_w:0]      r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_occ_w-1:0]   r_occ;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic                 w_tick;
    logic [N_BUTTONS-1:0] w_differ;
    logic [N_BUTTONS-1:0] w_accept;
    logic                 w_grant;
    logic [c_id_w-1:0]    w_grant_id;
    logic                 w_push;
    logic                 w_pop;
    logic [c_id_w:0]      w_head;

    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        logic [c_ptr_w-1:0] n;
        if (p == c_ptr_last) begin
            n = '0;
        end else begin
            n = p + 1'b1;
        end
        return n;
    endfunction

    // ------------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------------
    assign w_tick = (r_pre == c_tick_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-button acceptance decode
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
        assign w_differ[gi] = r_sync2[gi] ^ r_state[gi];
        // The sample that completes STABLE_TICKS differing samples is the
        // one that finds the counter at STABLE_TICKS-1.
        assign w_accept[gi] = w_tick & w_differ[gi] & (r_cnt[gi] == c_cnt_last);
    end

    // ------------------------------------------------------------------------
    // Round-robin arbiter: search starts one past the last granted index
    // ------------------------------------------------------------------------
    always_comb begin : p_arb
        logic [c_id_w-1:0] sel;
        int                idx;
        w_grant    = 1'b0;
        w_grant_id = '0;
        sel        = '0;
        idx        = 0;
        for (int k = 0; k < N_BUTTONS; k++) begin
            idx = (int'(r_last) + 1 + k) % N_BUTTONS;
            sel = c_id_w'(idx);
            if (!w_grant && r_pend[sel]) begin
                w_grant    = 1'b1;
                w_grant_id = sel;
            end
        end
    end

    // Admission looks only at the registered occupancy, so a same-cycle pop
    // does not open a slot for a push into a full queue.
    assign w_push = w_grant & (r_occ != c_occ_full);
    assign w_pop  = evt.read_en & (r_occ != '0);

    // ------------------------------------------------------------------------
    // Debounce counters, debounced state, pending events, overflow, arbiter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                r_cnt[i] <= '0;
            end
            r_state    <= '0;
            r_pend     <= '0;
            r_kind     <= '0;
            r_overflow <= 1'b0;
            r_last     <= c_last_rst;
        end else begin
            if (w_push) begin
                r_pend[w_grant_id] <= 1'b0;
                r_last             <= w_grant_id;
            end
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (w_tick) begin
                    if (!w_differ[i]) begin
                        r_cnt[i] <= '0;
                    end else if (w_accept[i]) begin
                        r_cnt[i]   <= '0;
                        r_state[i] <= r_sync2[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
                // Placed after the grant clear so a same-cycle set wins; the
                // entry pushed this cycle still carries the previous kind.
                if (w_accept[i]) begin
                    r_pend[i] <= 1'b1;
                    r_kind[i] <= r_sync2[i];
                    if (r_pend[i]) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Event queue (circular buffer, head read combinationally)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < FIFO_DEPTH; m++) begin
                r_mem[m] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_grant_id, r_kind[w_grant_id]};
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign w_head          = r_mem[r_rd_ptr];
    assign state           = r_state;
    assign evt.event_valid = (r_occ != '0);
    assign evt.fifo_full   = (r_occ == c_occ_full);
    assign evt.event_id    = w_head[c_id_w:1];
    assign evt.event_press = w_head[0];
    assign evt.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_button_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_scan_controller
// Description : Directed self-checking bench for button_scan_controller with
//               N_BUTTONS=4, TICK_DIV=4, STABLE_TICKS=3, FIFO_DEPTH=4.
//               Edge numbers count rising clock edges after reset release,
//               starting at 0; ticks are sampled on edges 3, 7, 11, ...
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_scan_controller;

    logic       clk;
    logic       reset_n;
    logic [3:0] buttons;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;
    int ecount   = -1;

    button_scan_controller_if #(.N_BUTTONS(4)) evt ();

    button_scan_controller #(
        .N_BUTTONS   (4),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .buttons(buttons),
        .state  (state),
        .evt    (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge, then settle 1 time unit for sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic step_to(input int n);
        while (ecount < n) step();
    endtask

    // Reset is released 1 unit after an edge; the following edge is edge 0.
    task automatic apply_reset();
        reset_n     = 1'b0;
        buttons     = 4'b0000;
        evt.read_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ecount  = -1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        buttons     = 4'b0000;
        evt.read_en = 1'b0;
        #3;
        checks++;
        if ({state, evt.event_valid, evt.event_id, evt.event_press,
             evt.fifo_full, evt.overflow} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b required=%b",
                     {state, evt.event_valid, evt.event_id, evt.event_press,
                      evt.fifo_full, evt.overflow}, 10'b0);
        end
    endtask

    task automatic test_clean_press();
        apply_reset();
        buttons = 4'b0100;
        step_to(10);
        checks++;
        if (state !== 4'b0000) begin
            failures++;
            $display("FAIL press_state_e10 actual=%b required=%b", state, 4'b0000);
        end
        step_to(11);
        checks++;
        if (state !== 4'b0100 || evt.event_valid !== 1'b0) begin
            failures++;
            $display("FAIL press_state_e11 actual=%b/%b required=0100/0", state, evt.event_valid);
        end
        step_to(12);
        checks++;
        if (evt.event_valid !== 1'b1 || evt.event_id !== 2'd2 || evt.event_press !== 1'b1) begin
            failures++;
            $display("FAIL press_event_e12 actual=%b/%0d/%b required=1/2/1",
                     evt.event_valid, evt.event_id, evt.event_press);
        end
        evt.read_en = 1'b1;
        step_to(13);
        evt.read_en = 1'b0;
        checks++;
        if (evt.event_valid !== 1'b0) begin
            failures++;
            $display("FAIL press_read_e13 actual=%b required=0", evt.event_valid);
        end
    endtask

    task automatic test_bounce();
        apply_reset();
        buttons = 4'b0001;
        step_to(5);
        buttons = 4'b0000;
        while (ecount < 39) begin
            step();
            checks++;
            if (state !== 4'b0000 || evt.event_valid !== 1'b0) begin
                failures++;
                $display("FAIL bounce_e%0d actual=%b/%b required=0000/0",
                         ecount, state, evt.event_valid);
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        buttons = 4'b1011;
        step_to(11);
        checks++;
        if (state !== 4'b1011 || evt.event_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_state_e11 actual=%b/%b required=1011/0", state, evt.event_valid);
        end
        step_to(12);
        checks++;
        if (evt.event_valid !== 1'b1 || evt.event_id !== 2'd0) begin
            failures++;
            $display("FAIL simul_first_e12 actual=%b/%0d required=1/0", evt.event_valid, evt.event_id);
        end
        step_to(14);
        checks++;
        if (evt.event_id !== 2'd0 || evt.event_press !== 1'b1 || evt.fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL simul_head_e14 actual=%0d/%b/%b required=0/1/0",
                     evt.event_id, evt.event_press, evt.fifo_full);
        end
        evt.read_en = 1'b1;
        step_to(15);
        checks++;
        if (evt.event_valid !== 1'b1 || evt.event_id !== 2'd1 || evt.event_press !== 1'b1) begin
            failures++;
            $display("FAIL simul_second actual=%b/%0d/%b required=1/1/1",
                     evt.event_valid, evt.event_id, evt.event_press);
        end
        step_to(16);
        checks++;
        if (evt.event_valid !== 1'b1 || evt.event_id !== 2'd3 || evt.event_press !== 1'b1) begin
            failures++;
            $display("FAIL simul_third actual=%b/%0d/%b required=1/3/1",
                     evt.event_valid, evt.event_id, evt.event_press);
        end
        step_to(17);
        evt.read_en = 1'b0;
        checks++;
        if (evt.event_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_empty actual=%b required=0", evt.event_valid);
        end
    endtask

    task automatic test_full_overflow();
        logic [1:0] exp_id [5];
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2;
        exp_id[3] = 2'd3; exp_id[4] = 2'd0;
        apply_reset();
        buttons = 4'b1111;
        step_to(14);
        checks++;
        if (evt.fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL full_e14 actual=%b required=0", evt.fifo_full);
        end
        step_to(15);
        checks++;
        if (evt.fifo_full !== 1'b1 || evt.event_id !== 2'd0) begin
            failures++;
            $display("FAIL full_e15 actual=%b/%0d required=1/0", evt.fifo_full, evt.event_id);
        end
        buttons = 4'b1110;
        step_to(27);
        checks++;
        if (state !== 4'b1110 || evt.overflow !== 1'b0) begin
            failures++;
            $display("FAIL release_e27 actual=%b/%b required=1110/0", state, evt.overflow);
        end
        buttons = 4'b1111;
        step_to(38);
        checks++;
        if (evt.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_e38 actual=%b required=0", evt.overflow);
        end
        step_to(39);
        checks++;
        if (evt.overflow !== 1'b1 || state !== 4'b1111 || evt.fifo_full !== 1'b1) begin
            failures++;
            $display("FAIL ovf_e39 actual=%b/%b/%b required=1/1111/1",
                     evt.overflow, state, evt.fifo_full);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (evt.event_valid !== 1'b1 || evt.event_id !== exp_id[k] || evt.event_press !== 1'b1) begin
                failures++;
                $display("FAIL drain_%0d actual=%b/%0d/%b required=1/%0d/1",
                         k, evt.event_valid, evt.event_id, evt.event_press, exp_id[k]);
            end
            evt.read_en = 1'b1;
            step();
        end
        evt.read_en = 1'b0;
        checks++;
        if (evt.event_valid !== 1'b0 || evt.overflow !== 1'b1 || evt.fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL drain_end actual=%b/%b/%b required=0/1/0",
                     evt.event_valid, evt.overflow, evt.fifo_full);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        buttons = 4'b0101;
        step_to(13);
        buttons = 4'b0111;
        checks++;
        if (evt.event_valid !== 1'b1 || evt.event_id !== 2'd0) begin
            failures++;
            $display("FAIL mid_pre_queue actual=%b/%0d required=1/0", evt.event_valid, evt.event_id);
        end
        step_to(23);
        checks++;
        if (state !== 4'b0101) begin
            failures++;
            $display("FAIL mid_pre_state actual=%b required=0101", state);
        end
        #2;
        reset_n = 1'b0;
        #2;
        checks++;
        if ({state, evt.event_valid, evt.event_id, evt.event_press,
             evt.fifo_full, evt.overflow} !== 10'b0) begin
            failures++;
            $display("FAIL mid_async_clear actual=%b required=%b",
                     {state, evt.event_valid, evt.event_id, evt.event_press,
                      evt.fifo_full, evt.overflow}, 10'b0);
        end
        buttons = 4'b1000;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ecount  = -1;
        while (ecount < 11) begin
            step();
            checks++;
            if (evt.event_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale_e%0d actual=%b required=0", ecount, evt.event_valid);
            end
            if (ecount == 10) begin
                checks++;
                if (state !== 4'b0000) begin
                    failures++;
                    $display("FAIL mid_state_e10 actual=%b required=0000", state);
                end
            end
        end
        checks++;
        if (state !== 4'b1000) begin
            failures++;
            $display("FAIL mid_state_e11 actual=%b required=1000", state);
        end
        step_to(12);
        checks++;
        if (evt.event_valid !== 1'b1 || evt.event_id !== 2'd3 || evt.event_press !== 1'b1) begin
            failures++;
            $display("FAIL mid_event_e12 actual=%b/%0d/%b required=1/3/1",
                     evt.event_valid, evt.event_id, evt.event_press);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_full_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
